// File: rtl/shift_reg_pkg.sv
// Shared types for the universal shift register.
package shift_reg_pkg;

  typedef enum logic [1:0] {
    SR_HOLD = 2'b00,
    SR_SHR  = 2'b01,
    SR_SHL  = 2'b10,
    SR_LOAD = 2'b11
  } shift_mode_t;

  // Counter width able to hold 0..max; never returns less than 1 bit.
  function automatic int clog2_safe(input int max);
    int w;
    w = 1;
    while ((1 << w) <= max) w++;
    return w;
  endfunction

endpackage

// File: rtl/shift_fill_ctr.sv
// Saturating fill counter: sync clear, sync load-to-max, increment that sticks at MAX.
module shift_fill_ctr #(
  parameter int MAX = 4,
  parameter int CW  = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          load_max,
  output logic [CW-1:0] count,
  output logic          at_max
);

  localparam logic [CW-1:0] MAXV = CW'(MAX);

  // Clear beats load, load beats increment; increment saturates rather than wrapping.
  always_ff @(posedge clk) begin
    if (!reset)                      count <= '0;
    else if (load_max)               count <= MAXV;
    else if (inc && (count != MAXV)) count <= count + 1'b1;
  end

  assign at_max = (count == MAXV);

endmodule

// File: rtl/shift_reg_universal.sv
// Universal shift register: DEPTH x WIDTH stages with hold / shift-right / shift-left / load,
// serial taps at both ends, full parallel readout and a saturating fill count.
module shift_reg_universal
  import shift_reg_pkg::*;
#(
  parameter  int WIDTH = 1,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       ser_in_r,
  input  logic [WIDTH-1:0]       ser_in_l,
  input  logic [DEPTH*WIDTH-1:0] par_in,
  output logic [WIDTH-1:0]       ser_out_r,
  output logic [WIDTH-1:0]       ser_out_l,
  output logic [DEPTH*WIDTH-1:0] par_out,
  output logic [CW-1:0]          fill,
  output logic                   full
);

  shift_mode_t md;
  assign md = shift_mode_t'(mode);

  logic [DEPTH-1:0][WIDTH-1:0] stage;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic [WIDTH-1:0] from_lo;  // source when shifting right (toward higher index)
    logic [WIDTH-1:0] from_hi;  // source when shifting left (toward lower index)
    logic [WIDTH-1:0] q;

    if (g == 0) begin : g_lo_edge
      assign from_lo = ser_in_r;
    end else begin : g_lo_mid
      assign from_lo = stage[g-1];
    end

    if (g == DEPTH-1) begin : g_hi_edge
      assign from_hi = ser_in_l;
    end else begin : g_hi_mid
      assign from_hi = stage[g+1];
    end

    // One stage: reset first, then enable, then a full 4-way mode decode.
    always_ff @(posedge clk) begin
      if (!reset) q <= '0;
      else if (en) begin
        case (md)
          SR_SHR:  q <= from_lo;
          SR_SHL:  q <= from_hi;
          SR_LOAD: q <= par_in[g*WIDTH +: WIDTH];
          default: q <= q;
        endcase
      end
    end

    assign stage[g] = q;
  end

  // Fill grows on any shift and jumps to DEPTH on load; direction changes leave it alone.
  shift_fill_ctr #(.MAX(DEPTH), .CW(CW)) u_fill (
    .clk      (clk),
    .reset    (reset),
    .inc      (en && ((md == SR_SHR) || (md == SR_SHL))),
    .load_max (en && (md == SR_LOAD)),
    .count    (fill),
    .at_max   (full)
  );

  assign par_out   = stage;
  assign ser_out_r = stage[DEPTH-1];
  assign ser_out_l = stage[0];

endmodule

// File: tb/tb_shift_reg_universal.sv
// Scoreboard bench: three instances (8x4, 3x2, 3x7) share control; a word-level model
// predicts every edge, a negedge monitor pops and compares.
module tb_shift_reg_universal;

  logic        clk = 1'b0;
  logic        rst_n, en;
  logic [1:0]  mode;
  logic [7:0]  sr, sl;
  logic [31:0] par;

  always #5 clk = ~clk;

  logic [7:0]  sor_a, sol_a;  logic [31:0] po_a; logic [2:0] fl_a; logic fu_a;
  logic [2:0]  sor_b, sol_b;  logic [5:0]  po_b; logic [1:0] fl_b; logic fu_b;
  logic [2:0]  sor_c, sol_c;  logic [20:0] po_c; logic [2:0] fl_c; logic fu_c;

  shift_reg_universal #(.WIDTH(8), .DEPTH(4)) u_a (
    .clk(clk), .reset(rst_n), .en(en), .mode(mode), .ser_in_r(sr), .ser_in_l(sl),
    .par_in(par), .ser_out_r(sor_a), .ser_out_l(sol_a), .par_out(po_a), .fill(fl_a), .full(fu_a));
  shift_reg_universal #(.WIDTH(3), .DEPTH(2)) u_b (
    .clk(clk), .reset(rst_n), .en(en), .mode(mode), .ser_in_r(sr[2:0]), .ser_in_l(sl[2:0]),
    .par_in(par[5:0]), .ser_out_r(sor_b), .ser_out_l(sol_b), .par_out(po_b), .fill(fl_b), .full(fu_b));
  shift_reg_universal #(.WIDTH(3), .DEPTH(7)) u_c (
    .clk(clk), .reset(rst_n), .en(en), .mode(mode), .ser_in_r(sr[2:0]), .ser_in_l(sl[2:0]),
    .par_in(par[20:0]), .ser_out_r(sor_c), .ser_out_l(sol_c), .par_out(po_c), .fill(fl_c), .full(fu_c));

  typedef struct {
    logic [63:0] p0, p1, p2;
    int          f0, f1, f2;
    bit          gold;
    logic [63:0] gpar;
    int          gfill;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference state: whole register as one integer, stage i at bits [i*w +: w].
  logic [63:0] pm [3];
  int          fm [3];

  function automatic int depk(input int k); return (k == 0) ? 4 : ((k == 1) ? 2 : 7); endfunction
  function automatic int widk(input int k); return (k == 0) ? 8 : 3; endfunction

  task automatic model_step(input int k, input bit r, input bit e, input logic [1:0] m,
                            input logic [7:0] a, input logic [7:0] b, input logic [31:0] p);
    int d, w;
    logic [63:0] fullm, lm;
    d = depk(k); w = widk(k);
    fullm = (64'd1 << (d*w)) - 64'd1;
    lm    = (64'd1 << w) - 64'd1;
    if (!r) begin
      pm[k] = 0; fm[k] = 0;
    end else if (e) begin
      if (m == 2'b01) begin
        pm[k] = ((pm[k] << w) | ({56'd0, a} & lm)) & fullm;
        fm[k] = (fm[k] + 1 > d) ? d : fm[k] + 1;
      end else if (m == 2'b10) begin
        pm[k] = (pm[k] >> w) | (({56'd0, b} & lm) << (w*(d-1)));
        fm[k] = (fm[k] + 1 > d) ? d : fm[k] + 1;
      end else if (m == 2'b11) begin
        pm[k] = {32'd0, p} & fullm;
        fm[k] = d;
      end
    end
  endtask

  task automatic drive(input bit r, input bit e, input logic [1:0] m, input logic [7:0] a,
                       input logic [7:0] b, input logic [31:0] p,
                       input bit g, input logic [63:0] gp, input int gf);
    exp_t x;
    @(negedge clk); #1;
    rst_n = r; en = e; mode = m; sr = a; sl = b; par = p;
    for (int k = 0; k < 3; k++) model_step(k, r, e, m, a, b, p);
    x.p0 = pm[0]; x.p1 = pm[1]; x.p2 = pm[2];
    x.f0 = fm[0]; x.f1 = fm[1]; x.f2 = fm[2];
    x.gold = g; x.gpar = gp; x.gfill = gf;
    sb.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [63:0] tap_r(input logic [63:0] p, input int k);
    return (p >> (widk(k)*(depk(k)-1))) & ((64'd1 << widk(k)) - 64'd1);
  endfunction
  function automatic logic [63:0] tap_l(input logic [63:0] p, input int k);
    return p & ((64'd1 << widk(k)) - 64'd1);
  endfunction

  exp_t e;
  // Monitor: every negedge, the oldest prediction belongs to the edge just taken.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("a.par_out", {32'd0, po_a}, e.p0);
      chk("a.fill", {61'd0, fl_a}, 64'(e.f0));
      chk("a.full", {63'd0, fu_a}, {63'd0, e.f0 == 4});
      chk("a.ser_out_r", {56'd0, sor_a}, tap_r(e.p0, 0));
      chk("a.ser_out_l", {56'd0, sol_a}, tap_l(e.p0, 0));
      chk("b.par_out", {58'd0, po_b}, e.p1);
      chk("b.fill", {62'd0, fl_b}, 64'(e.f1));
      chk("b.full", {63'd0, fu_b}, {63'd0, e.f1 == 2});
      chk("b.ser_out_r", {61'd0, sor_b}, tap_r(e.p1, 1));
      chk("b.ser_out_l", {61'd0, sol_b}, tap_l(e.p1, 1));
      chk("c.par_out", {43'd0, po_c}, e.p2);
      chk("c.fill", {61'd0, fl_c}, 64'(e.f2));
      chk("c.full", {63'd0, fu_c}, {63'd0, e.f2 == 7});
      chk("c.ser_out_r", {61'd0, sor_c}, tap_r(e.p2, 2));
      chk("c.ser_out_l", {61'd0, sol_c}, tap_l(e.p2, 2));
      if (e.gold) begin
        chk("a.par_out_gold", {32'd0, po_a}, e.gpar);
        chk("a.fill_gold", {61'd0, fl_a}, 64'(e.gfill));
      end
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 2'b00; sr = 0; sl = 0; par = 0;
    for (int k = 0; k < 3; k++) begin pm[k] = 0; fm[k] = 0; end

    // Reset state, then reset overriding a same-cycle shift after a load.
    drive(0, 0, 2'b00, 0, 0, 0, 1, 64'h0, 0);
    drive(1, 1, 2'b11, 0, 0, 32'h01000101, 1, 64'h01000101, 4);
    drive(0, 1, 2'b01, 8'hFF, 0, 0, 1, 64'h0, 0);

    // Serial right shift: first byte in reaches ser_out_r after DEPTH edges.
    drive(1, 1, 2'b01, 8'hA1, 0, 0, 1, 64'h000000A1, 1);
    drive(1, 1, 2'b01, 8'hB2, 0, 0, 1, 64'h0000A1B2, 2);
    drive(1, 1, 2'b01, 8'hC3, 0, 0, 1, 64'h00A1B2C3, 3);
    drive(1, 1, 2'b01, 8'hD4, 0, 0, 1, 64'hA1B2C3D4, 4);
    drive(1, 1, 2'b01, 8'hE5, 0, 0, 1, 64'hB2C3D4E5, 4);

    // Left shift with an en=0 stall in between (en=0 with a shift mode present).
    drive(0, 0, 2'b00, 0, 0, 0, 1, 64'h0, 0);
    drive(1, 1, 2'b10, 0, 8'h11, 0, 1, 64'h11000000, 1);
    drive(1, 0, 2'b10, 0, 8'h99, 0, 1, 64'h11000000, 1);
    drive(1, 0, 2'b10, 0, 8'h99, 0, 1, 64'h11000000, 1);
    drive(1, 1, 2'b10, 0, 8'h22, 0, 1, 64'h22110000, 2);

    // Parallel load then drain through ser_out_r.
    drive(1, 1, 2'b11, 0, 0, 32'h04030201, 1, 64'h04030201, 4);
    drive(1, 1, 2'b01, 8'h0F, 0, 0, 1, 64'h0302010F, 4);
    drive(1, 1, 2'b01, 8'h0F, 0, 0, 1, 64'h02010F0F, 4);
    drive(1, 1, 2'b01, 8'h0F, 0, 0, 1, 64'h010F0F0F, 4);
    drive(1, 1, 2'b01, 8'h0F, 0, 0, 1, 64'h0F0F0F0F, 4);

    // Enable outranks mode; HOLD keeps contents.
    drive(1, 1, 2'b11, 0, 0, 32'h0000ABCD, 1, 64'h0000ABCD, 4);
    drive(1, 0, 2'b11, 0, 0, 32'h0, 1, 64'h0000ABCD, 4);
    drive(1, 1, 2'b00, 8'h55, 8'h66, 32'h0, 1, 64'h0000ABCD, 4);

    // Random mix across all three geometries.
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 31) != 0, $urandom_range(0, 7) != 0,
            2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), $urandom, 0, 64'h0, 0);
    end

    repeat (3) @(negedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
